// File: rtl/ctrl_pkg.sv
// Control-bundle encodings, field layout and decode helpers shared by the decoder and pipeline.
package ctrl_pkg;
  localparam int CTRL_W = 25;

  localparam int REGWEN_O = 0;  localparam int REGWEN_W = 1;
  localparam int WBSEL_O  = 1;  localparam int WBSEL_W  = 2;
  localparam int LDSEL_O  = 3;  localparam int LDSEL_W  = 3;
  localparam int CSRSRC_O = 6;  localparam int CSRSRC_W = 1;
  localparam int MEMWEN_O = 7;  localparam int MEMWEN_W = 4;
  localparam int ALUSEL_O = 11; localparam int ALUSEL_W = 4;
  localparam int BRUN_O   = 15; localparam int BRUN_W   = 1;
  localparam int IMMSEL_O = 16; localparam int IMMSEL_W = 3;
  localparam int ISLOAD_O = 19; localparam int ISLOAD_W = 1;
  localparam int RD_O     = 20; localparam int RD_W     = 5;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_U = 3'd3, IMM_J = 3'd4, IMM_CSR = 3'd5
  } imm_sel_e;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3, ALU_SLTU = 4'd4,
    ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7, ALU_OR = 4'd8, ALU_AND = 4'd9,
    ALU_PASSB = 4'd10
  } alu_sel_e;

  typedef enum logic [1:0] {WB_MEM = 2'd0, WB_ALU = 2'd1, WB_PC4 = 2'd2, WB_CSR = 2'd3} wb_sel_e;

  typedef enum logic [2:0] {
    LD_LB = 3'd0, LD_LH = 3'd1, LD_LW = 3'd2, LD_LBU = 3'd3, LD_LHU = 3'd4, LD_NONE = 3'd7
  } ld_sel_e;

  // Declared MSB first so the packed layout matches the *_O offsets above.
  typedef struct packed {
    logic [4:0] rd;
    logic       is_load;
    imm_sel_e   imm_sel;
    logic       br_un;
    alu_sel_e   alu_sel;
    logic [3:0] mem_wen;
    logic       csr_src;
    ld_sel_e    ld_sel;
    wb_sel_e    wb_sel;
    logic       reg_wen;
  } ctrl_t;

  function automatic alu_sel_e alu_of(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction
endpackage

// File: rtl/ctrl_decode.sv
// Combinational RV32I control decoder. CSR write decode (csrw/csrwi) is enabled by CTRL_PIPE_CSR_EN;
// without it every SYSTEM opcode is illegal.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [31:0] inst,
  output ctrl_t       ctrl,
  output logic        uses_rs1,
  output logic        uses_rs2,
  output logic        illegal
);
  logic [6:0] op;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [4:0] rd;
  logic       wr;
  logic       unused_regs;

  assign op = inst[6:0];
  assign f3 = inst[14:12];
  assign f7 = inst[31:25];
  assign rd = inst[11:7];
  assign unused_regs = ^inst[24:15];

  always_comb begin
    ctrl         = '0;
    ctrl.ld_sel  = LD_NONE;
    ctrl.wb_sel  = WB_ALU;
    ctrl.alu_sel = ALU_ADD;
    ctrl.imm_sel = IMM_I;
    uses_rs1     = 1'b0;
    uses_rs2     = 1'b0;
    illegal      = 1'b0;
    wr           = 1'b0;
    case (op)
      OP_LUI:   begin ctrl.imm_sel = IMM_U; ctrl.alu_sel = ALU_PASSB; wr = 1'b1; end
      OP_AUIPC: begin ctrl.imm_sel = IMM_U; wr = 1'b1; end
      OP_JAL:   begin ctrl.imm_sel = IMM_J; ctrl.wb_sel = WB_PC4; wr = 1'b1; end
      OP_JALR: begin
        ctrl.wb_sel = WB_PC4; wr = 1'b1; uses_rs1 = 1'b1;
        illegal = (f3 != 3'b000);
      end
      OP_BRANCH: begin
        ctrl.imm_sel = IMM_B; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
        ctrl.br_un = (f3[2:1] == 2'b11);
        illegal = (f3[2:1] == 2'b01);
      end
      OP_LOAD: begin
        ctrl.wb_sel = WB_MEM; ctrl.is_load = 1'b1; wr = 1'b1; uses_rs1 = 1'b1;
        case (f3)
          3'b000:  ctrl.ld_sel = LD_LB;
          3'b001:  ctrl.ld_sel = LD_LH;
          3'b010:  ctrl.ld_sel = LD_LW;
          3'b100:  ctrl.ld_sel = LD_LBU;
          3'b101:  ctrl.ld_sel = LD_LHU;
          default: illegal = 1'b1;
        endcase
      end
      OP_STORE: begin
        ctrl.imm_sel = IMM_S; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
        case (f3)
          3'b000:  ctrl.mem_wen = 4'b0001;
          3'b001:  ctrl.mem_wen = 4'b0011;
          3'b010:  ctrl.mem_wen = 4'b1111;
          default: illegal = 1'b1;
        endcase
      end
      OP_IMM: begin
        wr = 1'b1; uses_rs1 = 1'b1;
        // imm[30] only selects SRA for shifts; for addi it is just immediate data
        ctrl.alu_sel = alu_of(f3, f7[5] && (f3 == 3'b101));
        illegal = ((f3 == 3'b001) && (f7 != 7'h00)) ||
                  ((f3 == 3'b101) && (f7 != 7'h00) && (f7 != 7'h20));
      end
      OP_REG: begin
        wr = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
        ctrl.alu_sel = alu_of(f3, f7[5]);
        illegal = (f7 != 7'h00) && !((f7 == 7'h20) && ((f3 == 3'b000) || (f3 == 3'b101)));
      end
      OP_FENCE: ;
      OP_SYSTEM: begin
`ifdef CTRL_PIPE_CSR_EN
        if (f3 == 3'b001 || f3 == 3'b101) begin
          ctrl.imm_sel = IMM_CSR; ctrl.wb_sel = WB_CSR; wr = 1'b1;
          ctrl.csr_src = f3[2];
          uses_rs1     = !f3[2];
        end else begin
          illegal = 1'b1;
        end
`else
        illegal = 1'b1;
`endif
      end
      default: illegal = 1'b1;
    endcase
    ctrl.reg_wen = wr && (rd != 5'd0);
    ctrl.rd      = wr ? rd : 5'd0;
    // an illegal instruction never reaches a slot, so it must not trigger a load-use bubble
    if (illegal) begin
      uses_rs1 = 1'b0;
      uses_rs2 = 1'b0;
    end
  end
endmodule

// File: rtl/ctrl_pipe.sv
// ID-stage control decode plus STAGES registered control slots (EX..WB) with stall/flush/load-use
// handling and a retired-instruction counter. CSR decode is optional via CTRL_PIPE_CSR_EN.
module ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int STAGES = 2,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       inst_i,
  input  logic              inst_valid_i,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic [2:0]        imm_sel_o,
  output logic              ready_o,
  output logic              ex_valid_o,
  output logic [CTRL_W-1:0] ex_ctrl_o,
  output logic              wb_valid_o,
  output logic [CTRL_W-1:0] wb_ctrl_o,
  output logic              illegal_o,
  output logic [CNT_W-1:0]  instret_o
);
  ctrl_t              dec;
  logic               uses_rs1, uses_rs2, dec_ill;
  logic               hazard, id_take, id_vld;
  ctrl_t [STAGES:1]   slot_q;
  logic  [STAGES:1]   vld_pipe;
  ctrl_t              ex;

  ctrl_decode u_dec (
    .inst     (inst_i),
    .ctrl     (dec),
    .uses_rs1 (uses_rs1),
    .uses_rs2 (uses_rs2),
    .illegal  (dec_ill)
  );

  assign ex = slot_q[1];

  assign hazard = inst_valid_i && vld_pipe[1] && ex.is_load && (ex.rd != 5'd0) &&
                  ((uses_rs1 && (inst_i[19:15] == ex.rd)) ||
                   (uses_rs2 && (inst_i[24:20] == ex.rd)));

  assign ready_o   = !stall_i && !hazard;
  assign id_take   = !stall_i && !flush_i && !hazard;
  assign id_vld    = inst_valid_i && !dec_ill;
  assign imm_sel_o = dec.imm_sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe  <= '0;
      slot_q    <= '0;
      illegal_o <= 1'b0;
      instret_o <= '0;
    end else begin
      illegal_o <= id_take && inst_valid_i && dec_ill;
      // slot 1: take ID, or a bubble on flush (even when stalled) / hazard; else hold
      if (id_take) begin
        vld_pipe[1] <= id_vld;
        slot_q[1]   <= id_vld ? dec : '0;
      end else if (flush_i || !stall_i) begin
        vld_pipe[1] <= 1'b0;
        slot_q[1]   <= '0;
      end
      if (!stall_i) begin
        for (int k = 2; k <= STAGES; k++) begin
          vld_pipe[k] <= vld_pipe[k-1];
          slot_q[k]   <= slot_q[k-1];
        end
      end
      if (wb_valid_o && !stall_i) instret_o <= instret_o + CNT_W'(1);
    end
  end

  assign ex_valid_o = vld_pipe[1];
  assign ex_ctrl_o  = slot_q[1];
  assign wb_valid_o = vld_pipe[STAGES];
  assign wb_ctrl_o  = slot_q[STAGES];
endmodule

// File: tb/tb_ctrl_pipe.sv
// Scoreboard bench for ctrl_pipe: expected EX bundles queued at issue, popped as they enter EX.
module tb_ctrl_pipe;
  localparam int STAGES = 2;
  localparam int CNT_W  = 32;

  localparam logic [24:0] M_RW  = 25'h0000001;
  localparam logic [24:0] M_WB  = 25'h0000006;
  localparam logic [24:0] M_LD  = 25'h0000038;
  localparam logic [24:0] M_CS  = 25'h0000040;
  localparam logic [24:0] M_MW  = 25'h0000780;
  localparam logic [24:0] M_ALU = 25'h0007800;
  localparam logic [24:0] M_BU  = 25'h0008000;
  localparam logic [24:0] M_IMM = 25'h0070000;
  localparam logic [24:0] M_ISL = 25'h0080000;
  localparam logic [24:0] M_RD  = 25'h1F00000;
  localparam logic [24:0] M_ALL = 25'h1FFFFFF;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [31:0]       inst_i = '0;
  logic              inst_valid_i = 1'b0, stall_i = 1'b0, flush_i = 1'b0;
  logic [2:0]        imm_sel_o;
  logic              ready_o, ex_valid_o, wb_valid_o, illegal_o;
  logic [24:0]       ex_ctrl_o, wb_ctrl_o;
  logic [CNT_W-1:0]  instret_o;

  typedef struct {logic [24:0] v; logic [24:0] m;} sb_t;
  sb_t  sb_q[$];
  sb_t  sb_e;
  int   nvec = 0, nerr = 0, exp_ret = 0;
  bit   held = 1'b0;
  logic [CNT_W-1:0] ret0;

  ctrl_pipe #(.STAGES(STAGES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .inst_i(inst_i), .inst_valid_i(inst_valid_i),
    .stall_i(stall_i), .flush_i(flush_i), .imm_sel_o(imm_sel_o), .ready_o(ready_o),
    .ex_valid_o(ex_valid_o), .ex_ctrl_o(ex_ctrl_o), .wb_valid_o(wb_valid_o),
    .wb_ctrl_o(wb_ctrl_o), .illegal_o(illegal_o), .instret_o(instret_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  function automatic logic [24:0] bnd(input int rd, input int isl, input int imm, input int bu,
                                      input int alu, input int mw, input int cs, input int ld,
                                      input int wb, input int rw);
    return {5'(rd), 1'(isl), 3'(imm), 1'(bu), 4'(alu), 4'(mw), 1'(cs), 3'(ld), 2'(wb), 1'(rw)};
  endfunction

  function automatic logic [24:0] addi_b(input int rd);
    return bnd(rd, 0, 0, 0, 0, 0, 0, 7, 1, 1);
  endfunction

  always @(posedge clk) held <= stall_i;

  always @(negedge clk) begin
    if (!rst && ex_valid_o && !held) begin
      if (sb_q.size() == 0) chk("sb_pop_empty", 32'(sb_q.size()), 1);
      else begin
        sb_e = sb_q.pop_front();
        chk("ex_ctrl", 32'(ex_ctrl_o & sb_e.m), 32'(sb_e.v & sb_e.m));
      end
    end
  end

  // called at a negedge; returns at the negedge after the instruction was accepted
  task automatic issue(input logic [31:0] in, input logic [24:0] v, input logic [24:0] m,
                       input bit push);
    int n;
    inst_i = in;
    inst_valid_i = 1'b1;
    #1;
    n = 0;
    while (!ready_o && n < 8) begin
      @(negedge clk); #1;
      n++;
    end
    chk("issue_ready", 32'(ready_o), 1);
    if (push) begin
      sb_q.push_back('{v, m});
      exp_ret++;
    end
    @(negedge clk);
    inst_valid_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    #2 rst = 1'b1;
    #1;
    chk("rst0_ex_valid", 32'(ex_valid_o), 0);
    chk("rst0_wb_valid", 32'(wb_valid_o), 0);
    chk("rst0_instret", instret_o, 0);
    chk("rst0_illegal", 32'(illegal_o), 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1 chk("idle_ready", 32'(ready_o), 1);
    @(negedge clk);

    // fill, then reset between edges
    issue(32'h00100093, addi_b(1), M_ALL, 1);
    issue(32'h00200113, addi_b(2), M_ALL, 1);
    issue(32'h00700393, addi_b(7), M_ALL, 1);
    chk("pre_rst_instret", instret_o, 1);
    chk("pre_rst_wb_valid", 32'(wb_valid_o), 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_ex_valid", 32'(ex_valid_o), 0);
    chk("rst_wb_valid", 32'(wb_valid_o), 0);
    chk("rst_ex_ctrl", 32'(ex_ctrl_o), 0);
    chk("rst_wb_ctrl", 32'(wb_ctrl_o), 0);
    chk("rst_instret", instret_o, 0);
    exp_ret = 0;
    @(negedge clk);
    rst = 1'b0;

    // load-use: lw x17 then add x1,x25,x17
    issue(32'h00852883, bnd(17, 1, 0, 0, 0, 0, 0, 2, 0, 1), M_ALL, 1);
    inst_i = 32'h011C80B3;
    inst_valid_i = 1'b1;
    #1 chk("lu_ready_low", 32'(ready_o), 0);
    @(negedge clk);
    chk("lu_ex_bubble", 32'(ex_valid_o), 0);
    chk("lu_wb_lw", 32'(wb_ctrl_o & M_ISL), 32'(M_ISL));
    #1 chk("lu_ready_high", 32'(ready_o), 1);
    sb_q.push_back('{bnd(1, 0, 0, 0, 0, 0, 0, 7, 1, 1), M_ALU | M_WB | M_RW | M_RD | M_LD});
    exp_ret++;
    @(negedge clk);
    inst_valid_i = 1'b0;

    // stores and branches
    issue(32'h0167a423, bnd(0, 0, 1, 0, 0, 15, 0, 7, 1, 0), M_IMM | M_MW | M_RW | M_ISL, 1);
    issue(32'h01468423, bnd(0, 0, 1, 0, 0, 1, 0, 7, 1, 0), M_IMM | M_MW | M_RW, 1);
    issue(32'h0666ee63, bnd(0, 0, 2, 1, 0, 0, 0, 7, 1, 0), M_IMM | M_BU | M_RW | M_MW, 1);

    // flush: beq in EX, addi x2 in ID gets dropped
    issue(32'h08248663, bnd(0, 0, 2, 0, 0, 0, 0, 7, 1, 0), M_IMM | M_BU | M_RW, 1);
    inst_i = 32'h00200113;
    inst_valid_i = 1'b1;
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    inst_valid_i = 1'b0;
    chk("fl_ex_valid", 32'(ex_valid_o), 0);
    chk("fl_ex_ctrl", 32'(ex_ctrl_o), 0);
    chk("fl_wb_valid", 32'(wb_valid_o), 1);
    chk("fl_wb_imm", 32'(wb_ctrl_o[18:16]), 2);
    chk("fl_wb_brun", 32'(wb_ctrl_o[15]), 0);

    // stall 3 cycles with all slots valid
    issue(32'h00300193, addi_b(3), M_ALL, 1);
    issue(32'h00400213, addi_b(4), M_ALL, 1);
    issue(32'h00500293, addi_b(5), M_ALL, 1);
    stall_i = 1'b1;
    inst_i = 32'h00600313;
    inst_valid_i = 1'b1;
    ret0 = instret_o;
    #1 chk("st_ready_low", 32'(ready_o), 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("st_ex_valid", 32'(ex_valid_o), 1);
      chk("st_ex_ctrl", 32'(ex_ctrl_o), 32'(addi_b(5)));
      chk("st_wb_valid", 32'(wb_valid_o), 1);
      chk("st_wb_ctrl", 32'(wb_ctrl_o), 32'(addi_b(4)));
      chk("st_instret", instret_o, ret0);
      chk("st_ready", 32'(ready_o), 0);
    end
    stall_i = 1'b0;
    #1 chk("st_ready_rel", 32'(ready_o), 1);
    sb_q.push_back('{addi_b(6), M_ALL});
    exp_ret++;
    @(negedge clk);
    inst_valid_i = 1'b0;
    chk("st_adv_wb", 32'(wb_ctrl_o), 32'(addi_b(5)));
    chk("st_adv_instret", instret_o, ret0 + 1);

    // csrwi x0
`ifdef CTRL_PIPE_CSR_EN
    issue(32'h51e0d073, bnd(0, 0, 5, 0, 0, 0, 1, 0, 0, 0), M_CS | M_IMM | M_RW, 1);
    chk("csr_no_illegal", 32'(illegal_o), 0);
`else
    issue(32'h51e0d073, '0, '0, 0);
    chk("csr_illegal", 32'(illegal_o), 1);
    chk("csr_ex_bubble", 32'(ex_valid_o), 0);
    @(negedge clk);
    chk("csr_illegal_pulse", 32'(illegal_o), 0);
`endif

    repeat (4) @(negedge clk);
    chk("sb_drained", 32'(sb_q.size()), 0);
    chk("instret_final", instret_o, 32'(exp_ret));
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
